vid_pattern_gen: RTL and testbench

AXI4-Stream video frame source for the video debug module. It is the transmit-side counterpart of the frame-size error checker.
- Emits frames of a programmable hsize x vsize, with tuser marking start-of-frame (SOF) and tlast marking end-of-line (EOL).
- Can deliberately corrupt one frame (early or late EOL, early or late SOF) so the checker's error flags can be exercised in hardware and in simulation.

---
 rtl/vid_dbg_pkg.sv | 41 ++++
 rtl/vid_pattern_data.sv | 37 +++
 rtl/vid_pattern_gen.sv | 248 ++++++++++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_dbg_pkg.sv
// Shared types for the video debug blocks.
//   state_e   : pattern generator FSM states
//   inject_e  : frame corruption types (encoding matches the inject_sel input)
//   pattern_e : pixel pattern selector (encoding matches the pattern_sel input)
//   MIN_SIZE  : smallest line length / frame height the generator will emit
package vid_dbg_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        INJ_NONE      = 3'd0,
        INJ_EOL_EARLY = 3'd1,
        INJ_EOL_LATE  = 3'd2,
        INJ_SOF_EARLY = 3'd3,
        INJ_SOF_LATE  = 3'd4
    } inject_e;

    typedef enum logic [1:0] {
        PAT_HRAMP   = 2'd0,
        PAT_VRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_FLAT    = 2'd3
    } pattern_e;

    localparam int MIN_SIZE = 2;

    // Codes 5-7 are reserved and behave as "no injection".
    function automatic inject_e decode_inject(input logic [2:0] sel);
        case (sel)
            3'd1:    return INJ_EOL_EARLY;
            3'd2:    return INJ_EOL_LATE;
            3'd3:    return INJ_SOF_EARLY;
            3'd4:    return INJ_SOF_LATE;
            default: return INJ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vid_pattern_data.sv
// Pixel value generator: purely combinational map of (pattern, x, y, frame count)
// to a tdata word.
// Ports:
//   pattern_i   : selected pattern
//   x_i, y_i    : pixel / line position of the beat
//   frame_cnt_i : low byte of the completed-frame counter (flat pattern)
//   data_o      : pixel value, DATA_WIDTH bits
module vid_pattern_data
    import vid_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int XW         = 12,
    parameter int YW         = 12
) (
    input  pattern_e                pattern_i,
    input  logic [XW-1:0]           x_i,
    input  logic [YW-1:0]           y_i,
    input  logic [7:0]              frame_cnt_i,
    output logic [DATA_WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        case (pattern_i)
            PAT_HRAMP:   data_o = DATA_WIDTH'(x_i);
            PAT_VRAMP:   data_o = DATA_WIDTH'(y_i);
            PAT_CHECKER: data_o = (x_i[3] ^ y_i[3]) ? '1 : '0;
            default: begin
                // Bytes fill from the MSB down; any bits below the last whole byte stay 0.
                for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                    data_o[DATA_WIDTH-1-8*i -: 8] = frame_cnt_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/vid_pattern_gen.sv
// AXI4-Stream video frame source. Emits hsize x vsize frames with tuser = SOF and
// tlast = EOL, and can corrupt a single frame (early/late EOL on line 0, or one
// line too few/many) to exercise a downstream frame-size checker.
// Ports:
//   aclk, resetn         : clock, synchronous active-low reset
//   enable               : frames are generated while high
//   hsize, vsize         : frame size, clamped to [2, MAX], sampled at frame start
//   pattern_sel          : 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 flat
//   inject_sel/req       : arm one corrupted frame (1 eol_early, 2 eol_late,
//                          3 sof_early, 4 sof_late)
//   m_axis_*             : registered AXI4-Stream master
//   frame_cnt            : completed frames, wraps
//   busy                 : FSM is ACTIVE
//   inject_done          : one-cycle pulse after the injected frame's last beat
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are both
// high. Once tvalid is raised, tvalid/tdata/tlast/tuser are held unchanged until
// that transfer; the x/y counters only move on a transfer.
module vid_pattern_gen
    import vid_dbg_pkg::*;
#(
    parameter int MAX_HSIZE  = 1920,
    parameter int MAX_VSIZE  = 1080,
    parameter int DATA_WIDTH = 24
) (
    input  logic                          aclk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [$clog2(MAX_HSIZE):0]    hsize,
    input  logic [$clog2(MAX_VSIZE):0]    vsize,
    input  logic [1:0]                    pattern_sel,
    input  logic [2:0]                    inject_sel,
    input  logic                          inject_req,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [31:0]                   frame_cnt,
    output logic                          busy,
    output logic                          inject_done
);

    // One extra bit over $clog2(MAX) so MAX+1 (eol_late / sof_late) fits.
    localparam int HW = $clog2(MAX_HSIZE) + 1;
    localparam int VW = $clog2(MAX_VSIZE) + 1;

    function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] v);
        if (v < HW'(MIN_SIZE))  return HW'(MIN_SIZE);
        if (v > HW'(MAX_HSIZE)) return HW'(MAX_HSIZE);
        return v;
    endfunction

    function automatic logic [VW-1:0] clamp_v(input logic [VW-1:0] v);
        if (v < VW'(MIN_SIZE))  return VW'(MIN_SIZE);
        if (v > VW'(MAX_VSIZE)) return VW'(MAX_VSIZE);
        return v;
    endfunction

    // Only line 0 of an EOL-injected frame has a modified length.
    function automatic logic [HW-1:0] line_len(input logic [HW-1:0] h, input inject_e inj,
                                               input logic [VW-1:0] y);
        if (y == '0 && inj == INJ_EOL_EARLY) return h - HW'(1);
        if (y == '0 && inj == INJ_EOL_LATE)  return h + HW'(1);
        return h;
    endfunction

    function automatic logic [VW-1:0] frame_ht(input logic [VW-1:0] v, input inject_e inj);
        if (inj == INJ_SOF_EARLY) return v - VW'(1);
        if (inj == INJ_SOF_LATE)  return v + VW'(1);
        return v;
    endfunction

    state_e                  state_q, state_d;
    logic [HW-1:0]           h_q, h_d;
    logic [VW-1:0]           v_q, v_d;
    pattern_e                pat_q, pat_d;
    inject_e                 cur_inj_q, cur_inj_d;
    logic                    armed_q, armed_d;
    inject_e                 arm_type_q, arm_type_d;
    logic [HW-1:0]           x_q, x_d;
    logic [VW-1:0]           y_q, y_d;
    logic                    tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic [31:0]             frame_cnt_q, frame_cnt_d;
    logic                    inject_done_q, inject_done_d;

    logic                    handshake;
    logic [HW-1:0]           cur_len;
    logic [VW-1:0]           cur_ht;
    logic                    last_beat;
    logic                    start;
    logic                    load;
    logic                    stop;
    logic [DATA_WIDTH-1:0]   pix_data;
    inject_e                 req_type;

    assign handshake = tvalid_q & m_axis_tready;
    assign cur_len   = line_len(h_q, cur_inj_q, y_q);
    assign cur_ht    = frame_ht(v_q, cur_inj_q);
    assign last_beat = (x_q == cur_len - HW'(1)) && (y_q == cur_ht - VW'(1));
    assign req_type  = decode_inject(inject_sel);

    // FSM, counters, config capture and injection arming.
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        pat_d         = pat_q;
        cur_inj_d     = cur_inj_q;
        armed_d       = armed_q;
        arm_type_d    = arm_type_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_cnt_d   = frame_cnt_q;
        inject_done_d = 1'b0;
        start         = 1'b0;
        load          = 1'b0;
        stop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) start = 1'b1;
            end
            ACTIVE: begin
                if (handshake) begin
                    if (last_beat) begin
                        frame_cnt_d   = frame_cnt_q + 32'd1;
                        inject_done_d = (cur_inj_q != INJ_NONE);
                        if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            cur_inj_d = INJ_NONE;
                            stop      = 1'b1;
                        end
                    end else begin
                        load = 1'b1;
                        if (x_q == cur_len - HW'(1)) begin
                            x_d = '0;
                            y_d = y_q + VW'(1);
                        end else begin
                            x_d = x_q + HW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d   = ACTIVE;
            h_d       = clamp_h(hsize);
            v_d       = clamp_v(vsize);
            pat_d     = pattern_e'(pattern_sel);
            cur_inj_d = armed_q ? arm_type_q : INJ_NONE;
            armed_d   = 1'b0;
            x_d       = '0;
            y_d       = '0;
            load      = 1'b1;
        end

        // Evaluated after the frame-start disarm, so a request coinciding with a
        // frame start arms the following frame. The registered arm and in-flight
        // state gate it, so a request is dropped while armed or injecting.
        if (inject_req && req_type != INJ_NONE && !armed_q && cur_inj_q == INJ_NONE) begin
            armed_d    = 1'b1;
            arm_type_d = req_type;
        end
    end

    vid_pattern_data #(
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (HW),
        .YW         (VW)
    ) u_data (
        .pattern_i   (pat_d),
        .x_i         (x_d),
        .y_i         (y_d),
        .frame_cnt_i (frame_cnt_d[7:0]),
        .data_o      (pix_data)
    );

    // Next AXI output word: the beat at (x_d, y_d) under the next-frame config.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = pix_data;
            tlast_d  = (x_d == line_len(h_d, cur_inj_d, y_d) - HW'(1));
            tuser_d  = (x_d == '0) && (y_d == '0);
        end else if (stop) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            pat_q         <= PAT_HRAMP;
            cur_inj_q     <= INJ_NONE;
            armed_q       <= 1'b0;
            arm_type_q    <= INJ_NONE;
            x_q           <= '0;
            y_q           <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            frame_cnt_q   <= '0;
            inject_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pat_q         <= pat_d;
            cur_inj_q     <= cur_inj_d;
            armed_q       <= armed_d;
            arm_type_q    <= arm_type_d;
            x_q           <= x_d;
            y_q           <= y_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            frame_cnt_q   <= frame_cnt_d;
            inject_done_q <= inject_done_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = (state_q == ACTIVE);
    assign inject_done   = inject_done_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen with small frame limits so clamps are reachable.
module tb_vid_pattern_gen;

    localparam int MAXH = 20;
    localparam int MAXV = 12;
    localparam int DW   = 24;
    localparam int HW   = $clog2(MAXH) + 1;
    localparam int VW   = $clog2(MAXV) + 1;

    logic          aclk;
    logic          resetn;
    logic          enable;
    logic [HW-1:0] hsize;
    logic [VW-1:0] vsize;
    logic [1:0]    pattern_sel;
    logic [2:0]    inject_sel;
    logic          inject_req;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [31:0]   frame_cnt;
    logic          busy;
    logic          inject_done;

    int checks = 0;
    int errors = 0;
    logic [DW+1:0] exp_q[$];   // {tuser, tlast, tdata}

    vid_pattern_gen #(
        .MAX_HSIZE  (MAXH),
        .MAX_VSIZE  (MAXV),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .enable        (enable),
        .hsize         (hsize),
        .vsize         (vsize),
        .pattern_sel   (pattern_sel),
        .inject_sel    (inject_sel),
        .inject_req    (inject_req),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_cnt     (frame_cnt),
        .busy          (busy),
        .inject_done   (inject_done)
    );

    // Clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within 300000 ns");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one frame of h x v; adj0 changes line 0's length by -1/0/+1.
    task automatic push_frame(input int h, input int v, input int pat, input int adj0, input int fc);
        for (int y = 0; y < v; y++) begin
            int l;
            l = (y == 0) ? h + adj0 : h;
            for (int x = 0; x < l; x++) begin
                logic [DW-1:0] d;
                logic [7:0]    fb;
                fb = fc[7:0];
                case (pat)
                    0:       d = DW'(x);
                    1:       d = DW'(y);
                    2:       d = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? '1 : '0;
                    default: d = {fb, fb, fb};
                endcase
                exp_q.push_back({1'(x == 0 && y == 0), 1'(x == l - 1), d});
            end
        end
    endtask

    // Accept n beats, comparing each against exp_q. rnd = random tready, else
    // tready = 1 and tvalid must be high every cycle. After beat number drop_at
    // is accepted, enable is dropped and hsize changed to new_h.
    task automatic drain(input int n, input bit rnd, input int drop_at,
                         input logic [HW-1:0] new_h, output int dones);
        int got;
        int idle;
        bit stalled;
        bit rdy;
        logic [DW+1:0] held;
        logic [DW+1:0] obs;
        logic [DW+1:0] exp;
        got = 0; idle = 0; stalled = 0; dones = 0; held = '0;
        while (got < n) begin
            @(negedge aclk);
            inject_req = 1'b0;
            obs = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (inject_done) dones++;
            if (stalled) begin
                chk("hold_valid", m_axis_tvalid, 1'b1);
                chk("hold_beat", obs, held);
            end
            if (!rnd) chk("no_bubble", m_axis_tvalid, 1'b1);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = rdy;
            if (m_axis_tvalid && rdy) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                chk("beat", obs, exp);
                got++;
                idle = 0;
                stalled = 0;
                if (got == drop_at) begin
                    enable = 1'b0;
                    hsize  = new_h;
                end
            end else begin
                stalled = m_axis_tvalid;
                held = obs;
                idle++;
                checks++;
                assert (idle < 100) else begin
                    errors++;
                    $error("FAIL beat_timeout: waited %0d cycles, limit 100", idle);
                end
                if (idle >= 100) got = n;
            end
        end
    endtask

    // Frame finished with enable low: idle next cycle and counter advanced.
    task automatic end_checks(input int fc);
        @(negedge aclk);
        chk("idle_tvalid", m_axis_tvalid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("frame_cnt", frame_cnt, 64'(fc));
    endtask

    initial begin
        int fc;
        int d;
        fc = 0;
        resetn = 1'b0; enable = 1'b0; hsize = 8; vsize = 4; pattern_sel = 0;
        inject_sel = 0; inject_req = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset state
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inject_done", inject_done, 1'b0);
        resetn = 1'b1;
        @(negedge aclk);
        chk("idle_no_enable", m_axis_tvalid, 1'b0);

        // Basic 8x4 h-ramp, one-cycle enable pulse
        enable = 1'b1;
        @(negedge aclk);
        chk("first_tvalid", m_axis_tvalid, 1'b1);
        chk("first_tuser", m_axis_tuser, 1'b1);
        chk("first_busy", busy, 1'b1);
        enable = 1'b0;
        push_frame(8, 4, 0, 0, fc);
        drain(32, 1'b0, 0, 8, d);
        fc++; end_checks(fc);

        // Same frame under random backpressure
        enable = 1'b1;
        push_frame(8, 4, 0, 0, fc);
        drain(32, 1'b1, 1, 8, d);
        fc++; end_checks(fc);

        // v-ramp 2x3
        hsize = 2; vsize = 3; pattern_sel = 1; enable = 1'b1;
        push_frame(2, 3, 1, 0, fc);
        drain(6, 1'b0, 1, 2, d);
        fc++; end_checks(fc);

        // checkerboard 16x2
        hsize = 16; vsize = 2; pattern_sel = 2; enable = 1'b1;
        push_frame(16, 2, 2, 0, fc);
        drain(32, 1'b0, 1, 16, d);
        fc++; end_checks(fc);

        // flat 2x2, two frames back to back (frame count changes between them)
        hsize = 2; vsize = 2; pattern_sel = 3; enable = 1'b1;
        push_frame(2, 2, 3, 0, fc);
        push_frame(2, 2, 3, 0, fc + 1);
        drain(8, 1'b0, 5, 2, d);
        fc += 2; end_checks(fc);

        // Mid-frame enable drop and hsize change, then a 16-wide frame
        hsize = 8; vsize = 4; pattern_sel = 0; enable = 1'b1;
        push_frame(8, 4, 0, 0, fc);
        drain(32, 1'b0, 10, 16, d);
        fc++; end_checks(fc);
        enable = 1'b1;
        push_frame(16, 4, 0, 0, fc);
        drain(64, 1'b0, 1, 16, d);
        fc++; end_checks(fc);

        // eol_early requested in the same cycle as a frame start: next frame injected
        hsize = 8; vsize = 4; enable = 1'b1; inject_sel = 1; inject_req = 1'b1;
        push_frame(8, 4, 0, 0, fc);
        push_frame(8, 4, 0, -1, fc + 1);
        drain(63, 1'b0, 40, 8, d);
        chk("eol_early_no_early_done", d, 0);
        fc += 2;
        @(negedge aclk);
        chk("eol_early_done", inject_done, 1'b1);
        chk("eol_early_idle", m_axis_tvalid, 1'b0);
        chk("eol_early_cnt", frame_cnt, 64'(fc));
        @(negedge aclk);
        chk("eol_early_done_pulse", inject_done, 1'b0);

        // sof_late armed while idle; a second request while armed is ignored
        inject_sel = 4; inject_req = 1'b1;
        @(negedge aclk);
        inject_sel = 1; inject_req = 1'b1;
        @(negedge aclk);
        inject_req = 1'b0; enable = 1'b1;
        push_frame(8, 5, 0, 0, fc);
        drain(40, 1'b0, 1, 8, d);
        fc++;
        @(negedge aclk);
        chk("sof_late_done", inject_done, 1'b1);
        chk("sof_late_cnt", frame_cnt, 64'(fc));

        // sof_early, v-ramp
        inject_sel = 3; inject_req = 1'b1; pattern_sel = 1;
        @(negedge aclk);
        inject_req = 1'b0; enable = 1'b1;
        push_frame(8, 3, 1, 0, fc);
        drain(24, 1'b0, 1, 8, d);
        fc++;
        @(negedge aclk);
        chk("sof_early_done", inject_done, 1'b1);

        // eol_late, 4x2 h-ramp
        inject_sel = 2; inject_req = 1'b1; pattern_sel = 0; hsize = 4; vsize = 2;
        @(negedge aclk);
        inject_req = 1'b0; enable = 1'b1;
        push_frame(4, 2, 0, 1, fc);
        drain(9, 1'b0, 1, 4, d);
        fc++;
        @(negedge aclk);
        chk("eol_late_done", inject_done, 1'b1);

        // Requests with none / reserved codes must not arm
        inject_sel = 0; inject_req = 1'b1;
        @(negedge aclk);
        inject_sel = 6; inject_req = 1'b1;
        @(negedge aclk);
        inject_req = 1'b0; enable = 1'b1;
        push_frame(4, 2, 0, 0, fc);
        drain(8, 1'b0, 1, 4, d);
        fc++;
        @(negedge aclk);
        chk("none_no_done", inject_done, 1'b0);
        chk("none_cnt", frame_cnt, 64'(fc));

        // Reset at beat 12 with an arm pending
        hsize = 8; vsize = 4; enable = 1'b1;
        push_frame(8, 4, 0, 0, fc);
        drain(12, 1'b0, 0, 8, d);
        @(negedge aclk);
        m_axis_tready = 1'b0; inject_sel = 1; inject_req = 1'b1;
        @(negedge aclk);
        inject_req = 1'b0; resetn = 1'b0; enable = 1'b0;
        @(negedge aclk);
        chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_tuser", m_axis_tuser, 1'b0);
        chk("mid_rst_tlast", m_axis_tlast, 1'b0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_busy", busy, 1'b0);
        resetn = 1'b1;
        exp_q.delete();
        fc = 0;
        enable = 1'b1;
        push_frame(8, 4, 0, 0, fc);
        drain(32, 1'b0, 1, 8, d);
        chk("rst_arm_cleared", d, 0);
        fc++;
        @(negedge aclk);
        chk("rst_arm_no_done", inject_done, 1'b0);
        chk("rst_cnt", frame_cnt, 64'(fc));

        // Clamps: 1x1 -> 2x2, hsize over max -> MAXH, vsize over max -> MAXV
        hsize = 1; vsize = 1; enable = 1'b1;
        push_frame(2, 2, 0, 0, fc);
        drain(4, 1'b0, 1, 1, d);
        fc++; end_checks(fc);
        hsize = 25; vsize = 2; enable = 1'b1;
        push_frame(20, 2, 0, 0, fc);
        drain(40, 1'b0, 1, 25, d);
        fc++; end_checks(fc);
        hsize = 2; vsize = 20; pattern_sel = 1; enable = 1'b1;
        push_frame(2, 12, 1, 0, fc);
        drain(24, 1'b0, 1, 2, d);
        fc++; end_checks(fc);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
